// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM controller port between instruction fetch and
// data memory; data wins ties, with a bounded wait for fetch.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              grant_dm
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              grant_dm_q, grant_dm_d;
    logic              fetch_starved;

    assign fetch_starved = if_req && (wait_cnt_q == WAIT_MAX);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        grant_dm_d  = grant_dm_q;
        unique case (state_q)
            IDLE: begin
                if (dm_req && !fetch_starved) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    grant_dm_d  = 1'b1;
                    state_d     = BUSY_DM;
                    if (if_req && wait_cnt_q != WAIT_MAX)
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end else if (if_req) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    grant_dm_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_valid) begin
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    state_d    = RESP;
                end
            end
            BUSY_DM: begin
                if (mem_valid) begin
                    // a write completion acks without touching read data
                    if (!mem_we_q)
                        dm_rdata_d = mem_rdata;
                    mem_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            grant_dm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            grant_dm_q  <= grant_dm_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: fetch, write, tie-break,
// starvation guard, spurious completion and mid-transaction reset.
module tb_sdram_port_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          grant_dm;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_WAIT(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .grant_dm (grant_dm)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, 32'(mem_req), 32'd1);
    endtask

    initial begin
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_if_ack", 32'(if_ack), 0);
        chk("rst_dm_ack", 32'(dm_ack), 0);
        chk("rst_grant", 32'(grant_dm), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_if_rdata", 32'(if_rdata), 0);
        chk("rst_dm_rdata", 32'(dm_rdata), 0);
        reset = 1'b1;
        tick();

        // single fetch, mem_valid in cycle 3, ack in cycle 4
        if_req  = 1'b1;
        if_addr = 25'h0010;
        tick();
        chk("f_c1_req", 32'(mem_req), 1);
        chk("f_c1_addr", 32'(mem_addr), 32'h10);
        chk("f_c1_we", 32'(mem_we), 0);
        chk("f_c1_grant", 32'(grant_dm), 0);
        tick();
        chk("f_c2_ack", 32'(if_ack), 0);
        tick();
        chk("f_c3_ack", 32'(if_ack), 0);
        chk("f_c3_req", 32'(mem_req), 1);
        mem_valid = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_valid = 1'b0;
        if_req    = 1'b0;
        chk("f_c4_ack", 32'(if_ack), 1);
        chk("f_c4_rdata", 32'(if_rdata), 32'hBEEF);
        chk("f_c4_req", 32'(mem_req), 0);
        chk("f_c4_dm_ack", 32'(dm_ack), 0);
        tick();
        chk("f_c5_ack", 32'(if_ack), 0);

        // data write held for three cycles
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 25'h1234;
        dm_wdata = 16'hA5A5;
        tick();
        chk("w_c1_we", 32'(mem_we), 1);
        chk("w_c1_addr", 32'(mem_addr), 32'h1234);
        chk("w_c1_wdata", 32'(mem_wdata), 32'hA5A5);
        chk("w_c1_grant", 32'(grant_dm), 1);
        tick();
        tick();
        chk("w_c3_req", 32'(mem_req), 1);
        chk("w_c3_wdata", 32'(mem_wdata), 32'hA5A5);
        chk("w_c3_we", 32'(mem_we), 1);
        mem_valid = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        dm_req = 1'b0;
        chk("w_ack", 32'(dm_ack), 1);
        chk("w_if_ack", 32'(if_ack), 0);
        chk("w_rdata_kept", 32'(dm_rdata), 0);
        chk("w_req_drop", 32'(mem_req), 0);
        // mem_valid left high through the ack cycle must be ignored
        tick();
        mem_valid = 1'b0;
        chk("w_resp_valid_ack", 32'(dm_ack), 0);
        chk("w_resp_valid_req", 32'(mem_req), 0);
        chk("w_grant_last", 32'(grant_dm), 1);

        // spurious completion in IDLE
        mem_valid = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_valid = 1'b0;
        chk("sp_if_ack", 32'(if_ack), 0);
        chk("sp_dm_ack", 32'(dm_ack), 0);
        chk("sp_req", 32'(mem_req), 0);
        chk("sp_if_rdata", 32'(if_rdata), 32'hBEEF);
        tick();

        // simultaneous requests: data first, then fetch
        if_req  = 1'b1;
        if_addr = 25'h0020;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 25'h0300;
        tick();
        chk("s_grant_dm", 32'(grant_dm), 1);
        chk("s_addr_dm", 32'(mem_addr), 32'h300);
        chk("s_we_dm", 32'(mem_we), 0);
        mem_valid = 1'b1;
        mem_rdata = 16'h1357;
        tick();
        mem_valid = 1'b0;
        dm_req    = 1'b0;
        chk("s_dm_ack", 32'(dm_ack), 1);
        chk("s_dm_rdata", 32'(dm_rdata), 32'h1357);
        chk("s_if_ack0", 32'(if_ack), 0);
        tick();
        chk("s_idle_req", 32'(mem_req), 0);
        tick();
        chk("s_if_req", 32'(mem_req), 1);
        chk("s_grant_if", 32'(grant_dm), 0);
        chk("s_addr_if", 32'(mem_addr), 32'h20);
        mem_valid = 1'b1;
        mem_rdata = 16'h2468;
        tick();
        mem_valid = 1'b0;
        if_req    = 1'b0;
        chk("s_if_ack", 32'(if_ack), 1);
        chk("s_if_rdata", 32'(if_rdata), 32'h2468);
        chk("s_dm_rdata_kept", 32'(dm_rdata), 32'h1357);
        tick();

        // starvation guard: two rounds of four data grants then fetch
        if_req  = 1'b1;
        if_addr = 25'h0040;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 25'h0500;
        for (int g = 0; g < 10; g++) begin
            wait_mem_req($sformatf("sv%0d", g));
            chk($sformatf("sv%0d_grant", g), 32'(grant_dm),
                32'(g % 5 != 4));
            mem_valid = 1'b1;
            mem_rdata = 16'(g);
            tick();
            mem_valid = 1'b0;
            chk($sformatf("sv%0d_dm_ack", g), 32'(dm_ack),
                32'(g % 5 != 4));
            chk($sformatf("sv%0d_if_ack", g), 32'(if_ack),
                32'(g % 5 == 4));
            tick();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        tick();

        // reset while BUSY_DM, then re-issue
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 25'h0ABC;
        dm_wdata = 16'h1111;
        tick();
        chk("r_req", 32'(mem_req), 1);
        chk("r_grant", 32'(grant_dm), 1);
        tick();
        reset = 1'b0;
        #1;
        chk("r_async_req", 32'(mem_req), 0);
        chk("r_async_grant", 32'(grant_dm), 0);
        chk("r_async_addr", 32'(mem_addr), 0);
        chk("r_async_we", 32'(mem_we), 0);
        tick();
        chk("r_hold_ack", 32'(dm_ack), 0);
        reset = 1'b1;
        wait_mem_req("r_reissue");
        chk("r_re_addr", 32'(mem_addr), 32'hABC);
        chk("r_re_we", 32'(mem_we), 1);
        chk("r_re_wdata", 32'(mem_wdata), 32'h1111);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        dm_req    = 1'b0;
        chk("r_re_ack", 32'(dm_ack), 1);
        tick();
        chk("r_re_ack_end", 32'(dm_ack), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
